// File: rtl/decode_issue_stage.sv
// Decode/issue stage: splits MIPS-style instruction fields, drives register-file read
// addresses and holds issue on RAW/WAW hazards tracked by a pending-write scoreboard.
module decode_issue_stage #(
  parameter int NREG = 32,
  parameter int IW   = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [IW-1:0] in_instr,
  output logic          in_ready,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [4:0]    Rreg1,
  output logic [4:0]    Rreg2,
  output logic [4:0]    dest_reg,
  output logic [5:0]    opcode,
  output logic [5:0]    funct,
  output logic [4:0]    shamt,
  output logic [31:0]   imm_ext,
  output logic [25:0]   jtarget,
  output logic          illegal,
  input  logic          wb_valid,
  input  logic [4:0]    wb_reg,
  output logic          stall
);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t          state, state_next;
  logic [NREG-1:0] pending, pending_next;

  logic [5:0]  dec_op;
  logic [4:0]  dec_rs, dec_rt, dec_rd;
  logic [4:0]  dec_src1, dec_src2, dec_dest;
  logic        dec_illegal;
  logic [31:0] dec_imm;
  logic        hazard;
  logic        accept;

  assign dec_op = in_instr[31:26];
  assign dec_rs = in_instr[25:21];
  assign dec_rt = in_instr[20:16];
  assign dec_rd = in_instr[15:11];

  // NOTE: every signal written in an always_comb gets a default first; a missing
  // assignment on any case branch would otherwise infer a latch.
  always_comb begin
    dec_src1    = '0;
    dec_src2    = '0;
    dec_dest    = '0;
    dec_illegal = 1'b0;
    case (dec_op)
      6'h00: begin
        dec_src1 = dec_rs;
        dec_src2 = dec_rt;
        dec_dest = dec_rd;
      end
      6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23: begin
        dec_src1 = dec_rs;
        dec_dest = dec_rt;
      end
      6'h2B, 6'h04, 6'h05: begin
        dec_src1 = dec_rs;
        dec_src2 = dec_rt;
      end
      6'h02: ;
      default: dec_illegal = 1'b1;
    endcase
  end

  // Logical immediates (andi/ori/xori) zero-extend; everything else sign-extends.
  always_comb begin
    if (dec_op inside {6'h0C, 6'h0D, 6'h0E})
      dec_imm = {16'h0000, in_instr[15:0]};
    else
      dec_imm = {{16{in_instr[15]}}, in_instr[15:0]};
  end

  // Register 0 never becomes pending, so indexing it contributes no hazard.
  assign hazard   = pending[dec_src1] | pending[dec_src2] | pending[dec_dest];
  assign stall    = in_valid & hazard;
  assign in_ready = !hazard && (state == EMPTY || out_ready);
  assign accept   = in_valid & in_ready;

  always_comb begin
    state_next = state;
    case (state)
      EMPTY:   if (accept) state_next = FULL;
      FULL:    if (out_ready && !accept) state_next = EMPTY;
      default: state_next = EMPTY;
    endcase
  end

  // Clear before set, so a register retired and re-issued in the same cycle stays pending.
  always_comb begin
    pending_next = pending;
    if (wb_valid && wb_reg != 5'd0) pending_next[wb_reg] = 1'b0;
    if (accept && dec_dest != 5'd0) pending_next[dec_dest] = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= EMPTY;
      pending <= '0;
    end else begin
      state   <= state_next;
      pending <= pending_next;
    end
  end

  assign out_valid = (state == FULL);

  // Decoded outputs load only on accept and otherwise hold their last value.
  always_ff @(posedge clk) begin
    if (rst) begin
      Rreg1    <= '0;
      Rreg2    <= '0;
      dest_reg <= '0;
      opcode   <= '0;
      funct    <= '0;
      shamt    <= '0;
      imm_ext  <= '0;
      jtarget  <= '0;
      illegal  <= 1'b0;
    end else if (accept) begin
      Rreg1    <= dec_src1;
      Rreg2    <= dec_src2;
      dest_reg <= dec_dest;
      opcode   <= dec_op;
      funct    <= in_instr[5:0];
      shamt    <= in_instr[10:6];
      imm_ext  <= dec_imm;
      jtarget  <= in_instr[25:0];
      illegal  <= dec_illegal;
    end
  end

endmodule

// File: tb/tb_decode_issue_stage.sv
// Directed bench for decode_issue_stage: decode fields, hazard stalls, backpressure,
// illegal opcodes, immediate extension and mid-operation reset.
module tb_decode_issue_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_instr;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  Rreg1, Rreg2, dest_reg, shamt, wb_reg;
  logic [5:0]  opcode, funct;
  logic [31:0] imm_ext;
  logic [25:0] jtarget;
  logic        illegal, wb_valid, stall;

  int checks   = 0;
  int failures = 0;

  decode_issue_stage dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_instr(in_instr), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready),
    .Rreg1(Rreg1), .Rreg2(Rreg2), .dest_reg(dest_reg),
    .opcode(opcode), .funct(funct), .shamt(shamt),
    .imm_ext(imm_ext), .jtarget(jtarget), .illegal(illegal),
    .wb_valid(wb_valid), .wb_reg(wb_reg), .stall(stall)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Advance one cycle and settle just past the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_instr = '0; out_ready = 1'b1;
    wb_valid = 1'b0; wb_reg = '0;
    tick(); tick();
    rst = 1'b0;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_dest", 32'(dest_reg), 32'd0);
    check("rst_rreg1", 32'(Rreg1), 32'd0);
    check("rst_illegal", 32'(illegal), 32'd0);
    check("rst_imm", imm_ext, 32'd0);
    check("rst_pending", dut.pending, 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // add $3,$1,$2
    in_valid = 1'b1; in_instr = 32'h00221820;
    #1;
    check("add_in_ready", 32'(in_ready), 32'd1);
    check("add_stall", 32'(stall), 32'd0);
    tick();
    check("add_out_valid", 32'(out_valid), 32'd1);
    check("add_rreg1", 32'(Rreg1), 32'd1);
    check("add_rreg2", 32'(Rreg2), 32'd2);
    check("add_dest", 32'(dest_reg), 32'd3);
    check("add_funct", 32'(funct), 32'h20);
    check("add_pending", dut.pending, 32'h0000_0008);

    // lw $4,8($3) stalls on pending $3
    in_instr = 32'h8C640008;
    #1;
    check("lw_stall", 32'(stall), 32'd1);
    check("lw_in_ready", 32'(in_ready), 32'd0);
    tick();
    check("lw_drain_out_valid", 32'(out_valid), 32'd0);
    wb_valid = 1'b1; wb_reg = 5'd3;
    #1;
    check("lw_no_bypass_stall", 32'(stall), 32'd1);
    tick();
    wb_valid = 1'b0;
    check("lw_wb_cleared", dut.pending, 32'd0);
    #1;
    check("lw_released_in_ready", 32'(in_ready), 32'd1);
    tick();
    check("lw_out_valid", 32'(out_valid), 32'd1);
    check("lw_rreg1", 32'(Rreg1), 32'd3);
    check("lw_rreg2", 32'(Rreg2), 32'd0);
    check("lw_dest", 32'(dest_reg), 32'd4);
    check("lw_imm", imm_ext, 32'h0000_0008);
    check("lw_opcode", 32'(opcode), 32'h23);
    check("lw_pending", dut.pending, 32'h0000_0010);

    // add $5,$4,$4 stalls; retire $4
    in_instr = 32'h00842820; wb_valid = 1'b1; wb_reg = 5'd4;
    #1;
    check("add2_stall", 32'(stall), 32'd1);
    tick();
    check("add2_wb_cleared", dut.pending, 32'd0);
    // lw $4,0($0) issues while a stray writeback of $4 arrives: set wins
    in_instr = 32'h8C040000;
    #1;
    check("lw2_in_ready", 32'(in_ready), 32'd1);
    tick();
    wb_valid = 1'b0;
    check("lw2_clear_set_pending", dut.pending, 32'h0000_0010);
    check("lw2_dest", 32'(dest_reg), 32'd4);
    check("lw2_rreg1", 32'(Rreg1), 32'd0);
    in_instr = 32'h00842820;
    #1;
    check("add3_stall", 32'(stall), 32'd1);
    tick();
    check("add3_still_stall", 32'(stall), 32'd1);
    check("add3_out_valid", 32'(out_valid), 32'd0);
    wb_valid = 1'b1; wb_reg = 5'd4;
    tick();
    wb_valid = 1'b0;
    #1;
    check("add3_released", 32'(stall), 32'd0);
    tick();
    check("add3_dest", 32'(dest_reg), 32'd5);
    check("add3_pending", dut.pending, 32'h0000_0020);

    // Backpressure: add $8,$6,$7 waits behind held add $5
    out_ready = 1'b0; in_instr = 32'h00C74020;
    #1;
    check("bp_in_ready", 32'(in_ready), 32'd0);
    check("bp_stall", 32'(stall), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_hold_valid", 32'(out_valid), 32'd1);
      check("bp_hold_dest", 32'(dest_reg), 32'd5);
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", 32'(in_ready), 32'd1);
    tick();
    check("bp_next_dest", 32'(dest_reg), 32'd8);
    check("bp_next_valid", 32'(out_valid), 32'd1);
    in_instr = 32'h00C74822;
    tick();
    check("bp_b2b_dest", 32'(dest_reg), 32'd9);
    check("bp_b2b_funct", 32'(funct), 32'h22);
    in_valid = 1'b0;
    tick();
    check("bp_drain_valid", 32'(out_valid), 32'd0);
    check("bp_pending", dut.pending, 32'h0000_0320);

    // Illegal opcode and immediate extension
    in_valid = 1'b1; in_instr = 32'hFC000000;
    tick();
    check("ill_illegal", 32'(illegal), 32'd1);
    check("ill_dest", 32'(dest_reg), 32'd0);
    check("ill_opcode", 32'(opcode), 32'h3F);
    check("ill_pending", dut.pending, 32'h0000_0320);
    in_instr = 32'h2000FFFF;
    tick();
    check("addi_imm", imm_ext, 32'hFFFF_FFFF);
    check("addi_illegal", 32'(illegal), 32'd0);
    check("addi_pending", dut.pending, 32'h0000_0320);
    in_instr = 32'h3000FFFF;
    tick();
    check("andi_imm", imm_ext, 32'h0000_FFFF);
    in_instr = 32'h08000123;
    tick();
    check("j_jtarget", 32'(jtarget), 32'h0000_0123);
    check("j_rreg1", 32'(Rreg1), 32'd0);
    check("j_dest", 32'(dest_reg), 32'd0);
    in_valid = 1'b0;

    // Retire $5/$8/$9, then reset while FULL with $3 pending
    wb_valid = 1'b1;
    wb_reg = 5'd5; tick();
    wb_reg = 5'd8; tick();
    wb_reg = 5'd9; tick();
    wb_valid = 1'b0;
    check("wb_all_cleared", dut.pending, 32'd0);
    in_valid = 1'b1; in_instr = 32'h00221820;
    tick();
    check("pre_rst_pending", dut.pending, 32'h0000_0008);
    out_ready = 1'b0; in_instr = 32'h8C640008;
    #1;
    check("pre_rst_stall", 32'(stall), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_pending", dut.pending, 32'd0);
    check("mid_rst_dest", 32'(dest_reg), 32'd0);
    #1;
    check("post_rst_in_ready", 32'(in_ready), 32'd1);
    tick();
    check("post_rst_valid", 32'(out_valid), 32'd1);
    check("post_rst_rreg1", 32'(Rreg1), 32'd3);
    check("post_rst_dest", 32'(dest_reg), 32'd4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/decode_issue_stage.md
Name: decode_issue_stage

Overview:
- Instruction decode/issue stage that sits directly upstream of the register file.
- Accepts 32-bit MIPS-style instructions from fetch over a valid/ready handshake and splits out the fields.
- Drives the register-file read addresses (Rreg1/Rreg2) and destination register number.
- Keeps a 32-entry pending-write scoreboard and stalls issue on RAW/WAW hazards until writeback clears them.

Parameters:
- NREG, 32, number of architectural registers; register index width is 5.
- IW, 32, instruction width.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  fetch presents an instruction.
- in_instr  input  32  instruction word.
- in_ready  output  1  stage accepts in_instr this cycle.
- out_valid  output  1  decoded instruction held on outputs.
- out_ready  input  1  downstream consumes the held instruction.
- Rreg1  output  5  read address 1 (rs, or 0 if unused).
- Rreg2  output  5  read address 2 (rt, or 0 if unused).
- dest_reg  output  5  destination register (0 = no write).
- opcode  output  6  instr[31:26].
- funct  output  6  instr[5:0].
- shamt  output  5  instr[10:6].
- imm_ext  output  32  sign-extended instr[15:0] (zero-extended for opcodes 0x0C-0x0E).
- jtarget  output  26  instr[25:0].
- illegal  output  1  opcode not in the decode set.
- wb_valid  input  1  writeback completes this cycle.
- wb_reg  input  5  register being written back.
- stall  output  1  in_valid high but blocked by a hazard.

Behaviour:
- Reset: out_valid=0, all decoded outputs=0, illegal=0, scoreboard=all 0, state=EMPTY. in_ready=1 from the first cycle after reset.
- Reset mid-operation drops the held instruction and clears all pending bits; no writeback is required afterwards.
- Decode set (src1/src2/dest):
  - R-type, opcode 0x00: rs / rt / rd.
  - I-ALU, opcode 0x08-0x0F: rs / none / rt.
  - lw, 0x23: rs / none / rt.
  - sw, 0x2B: rs / rt / none.
  - beq 0x04, bne 0x05: rs / rt / none.
  - j, 0x02: none / none / none.
  - Anything else: illegal=1, all registers 0, no scoreboard effect.
- Unused source reports 0 on Rreg1/Rreg2. Register 0 is never pending and never a hazard.
- Hazard: pending[src1] | pending[src2] | pending[dest], evaluated on in_instr using the registered scoreboard.
  - A wb_valid clear in the same cycle is NOT bypassed; the stall lasts one extra cycle.
- stall = in_valid & hazard. in_ready = !hazard & (state==EMPTY | out_ready).
- Accept = in_valid & in_ready. On accept, next cycle:
  - Outputs are loaded and out_valid=1.
  - pending[dest] is set if dest != 0.
- Latency: 1 cycle from accept to out_valid.
- Throughput: 1 instruction per cycle when out_ready=1 and there are no hazards.
- State machine (2 states):
  - EMPTY -> FULL on accept.
  - FULL -> FULL on out_ready & accept (back-to-back).
  - FULL -> EMPTY on out_ready & !accept.
  - FULL holds while out_ready=0; outputs stay stable.
- Scoreboard update priority per cycle: clear (wb_valid, wb_reg != 0) first, then set (accept).
  - Same register cleared and set in one cycle ends pending=1.
  - wb_valid for a non-pending register, or for register 0, is ignored.
- out_valid must not depend combinationally on out_ready. Outputs change only on a clock edge.

Test Plan:
- Reset then in_instr=0x00221820 (add $3,$1,$2), out_ready=1 -> next cycle out_valid=1, Rreg1=1, Rreg2=2, dest_reg=3, pending[3]=1.
- After that, in_instr=0x8C640008 (lw $4,8($3)) -> stall=1, in_ready=0. Pulse wb_valid with wb_reg=3 -> accepted one cycle later; Rreg1=3, Rreg2=0, dest_reg=4, imm_ext=0x00000008.
- With pending[4]=1, in_instr=0x00842820 (add $5,$4,$4) and wb_valid/wb_reg=4 asserted in the same cycle the lw issues a new $4 write -> pending[4] stays 1 and the add keeps stalling.
- out_ready=0 for 3 cycles while FULL with a non-hazard instruction waiting -> in_ready=0, outputs unchanged. Release out_ready -> one transfer per cycle, no loss or duplication.
- in_instr=0xFC000000 -> illegal=1, dest_reg=0, scoreboard unchanged. in_instr=0x2000FFFF (addi $0,$0,-1) -> imm_ext=0xFFFFFFFF, pending[0] stays 0.
- Assert rst while FULL with pending[3]=1 -> next cycle out_valid=0, scoreboard=0, and a stalled instruction that read $3 is accepted immediately.
